// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/ack data-bus transaction per MemRead/MemWrite and stalls the core until it retires.
// Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusByteEn,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e      state_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        ld_q;

  logic        req, is_ld, fault;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;

  assign req   = MemRead | MemWrite;
  assign is_ld = MemRead & ~MemWrite;
  assign Stall = (state_q == S_ACCESS) || (state_q == S_IDLE && req);

  always_comb begin
    fault    = 1'b0;
    st_wdata = WriteData;
    st_be    = 4'b1111;
    case (Funct3)
      3'b000, 3'b100: begin
        st_wdata = {4{WriteData[7:0]}};
        st_be    = 4'b0001 << ALUResult[1:0];
      end
      3'b001, 3'b101: begin
        fault    = ALUResult[0];
        st_wdata = {2{WriteData[15:0]}};
        st_be    = 4'b0011 << ALUResult[1:0];
      end
      3'b010:  fault = |ALUResult[1:0];
      default: fault = 1'b1;
    endcase
    if (!MemWrite) st_be = 4'b1111;
  end

  // Lane select uses the offset captured at request time, not the live address.
  assign ld_b = BusRData[8*off_q +: 8];
  assign ld_h = BusRData[16*off_q[1] +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_fmt = {24'd0, ld_b};
      3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_fmt = {16'd0, ld_h};
      default: ld_fmt = BusRData;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;
  assign BusErr = bus_err_q;
`else
  // No counter: a silent responder stalls the core indefinitely.
  assign BusErr = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      ld_q        <= 1'b0;
      ReadData    <= 32'd0;
      MisalignErr <= 1'b0;
      BusReq      <= 1'b0;
      BusWe       <= 1'b0;
      BusAddr     <= 32'd0;
      BusWData    <= 32'd0;
      BusByteEn   <= 4'd0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      MisalignErr <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req) begin
            f3_q      <= Funct3;
            off_q     <= ALUResult[1:0];
            ld_q      <= is_ld;
            BusWe     <= MemWrite;
            BusAddr   <= {ALUResult[31:2], 2'b00};
            BusWData  <= st_wdata;
            BusByteEn <= st_be;
            if (fault) begin
              state_q     <= S_DONE;
              MisalignErr <= 1'b1;
              if (is_ld) ReadData <= 32'd0;
            end else begin
              state_q <= S_ACCESS;
              BusReq  <= 1'b1;
`ifdef LSU_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end
        end
        S_ACCESS: begin
          if (BusAck) begin
            BusReq  <= 1'b0;
            state_q <= S_DONE;
            if (ld_q) ReadData <= ld_fmt;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            BusReq    <= 1'b0;
            state_q   <= S_DONE;
            bus_err_q <= 1'b1;
            if (ld_q) ReadData <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized loads/stores against a reference model.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, MisalignErr, BusErr, BusReq, BusWe;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusByteEn;
  logic        BusAck;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] rd_model = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .MisalignErr(MisalignErr), .BusErr(BusErr), .BusReq(BusReq), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusWData(BusWData), .BusByteEn(BusByteEn),
    .BusAck(BusAck), .BusRData(BusRData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return 32'($signed(sh[15:0]));
      3'd5:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // One full instruction: drive request, act as bus responder after dly wait cycles, check retirement.
  task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int dly,
                       input logic [31:0] rdat);
    int stalls, waits, sz, exp_stalls;
    bit saw_req, done, legal, flt, tmo;
    logic [31:0] c_addr, c_wd, exp_wd;
    logic [3:0]  c_be, exp_be;
    logic        c_we;

    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    sz    = 1 << f3[1:0];
    flt   = !legal || ((int'(addr[1:0]) % sz) != 0);
    tmo   = 1'b0;
`ifdef LSU_TIMEOUT_EN
    tmo   = !flt && (dly >= TMO);
`endif
    case (f3[1:0])
      2'd0:    exp_wd = {4{wd[7:0]}};
      2'd1:    exp_wd = {2{wd[15:0]}};
      default: exp_wd = wd;
    endcase
    exp_be = wr ? 4'(((1 << sz) - 1) << addr[1:0]) : 4'hF;
    if (rd && !wr) rd_model = (flt || tmo) ? 32'd0 : ref_load(f3, addr[1:0], rdat);
    exp_stalls = flt ? 1 : (tmo ? 1 + TMO : 2 + dly);

    stalls = 0; waits = 0; saw_req = 0; done = 0;
    c_addr = '0; c_wd = '0; c_be = '0; c_we = 1'b0;
    @(negedge clk);
    BusAck = 1'b0;
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!Stall) done = 1;
      else begin
        stalls++;
        if (BusReq) begin
          saw_req = 1; c_addr = BusAddr; c_wd = BusWData; c_be = BusByteEn; c_we = BusWe;
          if (waits == dly) begin BusAck = 1'b1; BusRData = rdat; end
          else waits++;
        end
        @(negedge clk);
        BusAck = 1'b0;
        BusRData = $urandom;
      end
    end
    chk({tag, "_retired"}, 32'(done), 32'd1);
    if (done) begin
      chk({tag, "_stalls"}, stalls, exp_stalls);
      chk({tag, "_misalign"}, 32'(MisalignErr), 32'(flt));
      chk({tag, "_buserr"}, 32'(BusErr), 32'(tmo));
      chk({tag, "_req_done"}, 32'(BusReq), 32'd0);
      chk({tag, "_rdata"}, ReadData, rd_model);
      chk({tag, "_bus_used"}, 32'(saw_req), 32'(!flt));
      if (saw_req) begin
        chk({tag, "_addr"}, c_addr, addr & ~32'd3);
        chk({tag, "_we"}, 32'(c_we), 32'(wr));
        chk({tag, "_be"}, 32'(c_be), 32'(exp_be));
        if (wr) chk({tag, "_wdata"}, c_wd, exp_wd);
      end
    end
    // Gap cycle: drop request and throw a stray ack at IDLE, which must be ignored.
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    BusAck = 1'($urandom_range(0, 1));
    BusRData = $urandom;
    #1;
    chk({tag, "_pulse_end"}, {30'd0, MisalignErr, BusErr}, 32'd0);
    chk({tag, "_idle"}, 32'(Stall), 32'd0);
  endtask

  initial begin
    bit got_req;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
    ALUResult = '0; WriteData = '0; BusAck = 1'b0; BusRData = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_addr", BusAddr, 32'd0);
    chk("rst_wdata", BusWData, 32'd0);
    chk("rst_flags", {25'd0, BusByteEn, BusReq, BusWe, MisalignErr}, 32'd0);
    chk("rst_buserr_stall", {30'd0, BusErr, Stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("t1_lw", 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("t1_value", ReadData, 32'hDEADBEEF);
    do_op("t2_lb", 1, 0, 3'b000, 32'h103, 32'h0, 3, 32'h80FF1234);
    chk("t2_lb_value", ReadData, 32'hFFFFFF80);
    do_op("t2_lbu", 1, 0, 3'b100, 32'h103, 32'h0, 3, 32'h80FF1234);
    chk("t2_lbu_value", ReadData, 32'h00000080);
    do_op("t3_sh", 0, 1, 3'b001, 32'h0A, 32'h1234ABCD, 1, 32'h0);
    do_op("t3_lh", 1, 0, 3'b001, 32'h2E, 32'h0, 0, 32'h8001_7FFF);
    do_op("t4_lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    chk("t4_value", ReadData, 32'd0);
    do_op("t_lhu", 1, 0, 3'b101, 32'h46, 32'h0, 2, 32'h9ABC_0001);
    do_op("t_both", 1, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 32'h11111111);
    chk("t_both_keep", ReadData, 32'h00009ABC);
    do_op("t_illegal", 1, 0, 3'b111, 32'h40, 32'h0, 0, 32'h0);

    // Reset while the bus never acks: abandon the access immediately.
    @(negedge clk);
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h40;
    got_req = 0;
    for (int c = 0; c < 10 && !got_req; c++) begin
      @(negedge clk); #1;
      if (BusReq) got_req = 1;
    end
    chk("t5_req_seen", 32'(got_req), 32'd1);
    #2 reset = 1'b1;
    #1 chk("t5_req_drop", 32'(BusReq), 32'd0);
    MemRead = 1'b0;
    #1 chk("t5_idle", 32'(Stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_model = 32'd0;
    do_op("t5_lw", 1, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0BAD_F00D);

`ifdef LSU_TIMEOUT_EN
    do_op("t6_tmo", 1, 0, 3'b010, 32'h200, 32'h0, 1000, 32'h12345678);
    chk("t6_value", ReadData, 32'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(1, 3));
      do_op($sformatf("rnd%0d", i), kind[0], kind[1], 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
